if_id_queue: RTL and testbench
==============================

# if_id_queue

Decoupling instruction queue between the fetch stage and decode. It accepts fetched `if_id_reg_t` packets from IF and presents them in order to ID as a first-word-fall-through FIFO. It back-pressures fetch through `in_ready`, which the hazard unit folds into `pc_stall`. It discards all queued packets on a branch-redirect flush from EX.

## Interface
- `DEPTH`, default 4: number of entries. Must be a power of two, ≥2.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  fetch offers a packet this cycle.
- `in`  input  if_id_reg_t  fetched packet (`pc`, `instruction`, `pc_plus4`, `valid_if_id`).
- `in_ready`  output  1  queue can accept a packet this cycle.
- `flush`  input  1  branch redirect from EX; drops all queued and incoming packets.
- `out`  output  if_id_reg_t  head packet presented to decode.
- `out_valid`  output  1  head packet present.
- `out_ready`  input  1  decode consumes the head this cycle.
- `count`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage:
  - DEPTH-entry array of `if_id_reg_t`.
  - Write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Registered occupancy counter `count`.
- Push condition: `in_valid && in_ready && in.valid_if_id && !flush`. A packet with `valid_if_id=0` is accepted by the handshake but not stored.
- Pop condition: `out_valid && out_ready && !flush`.
- `in_ready = (count != DEPTH)`. When full, no push occurs even if a pop happens the same cycle. `in_ready` does not depend combinationally on `out_ready`.
- `out_valid = (count != 0)`.
- `out`:
  - When non-empty: the entry at `rd_ptr`, with `valid_if_id=1`.
  - When empty: `pc=0`, `pc_plus4=0`, `instruction=32'h00000013` (NOP), `valid_if_id=0`.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, with both pointers advancing.
  - neither: unchanged.
- Flush has priority over everything:
  - Next cycle: `wr_ptr=rd_ptr=0`, `count=0`.
  - Any same-cycle push or pop is suppressed.
  - Array contents need not be cleared.
- Reset behaves like flush and overrides flush, push and pop. Reset asserted mid-operation discards all contents.
- `count` never exceeds DEPTH and never underflows. Verification asserts both conditions.

## Timing
- Latency: a packet pushed in cycle N is visible on `out` with `out_valid=1` in cycle N+1. There is no same-cycle bypass into an empty queue.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- `in_ready`, `out_valid`, `out` and `count` all derive from registered state only. None of them has a combinational path from `in_valid`, `out_ready` or `flush`.
- After `flush` in cycle N: in cycle N+1, `out_valid=0`, `count=0`, `in_ready=1`. The first post-redirect packet pushed in N+1 appears at the output in N+2.
- Reset values of outputs:
  - `in_ready=1`, `out_valid=0`, `count=0`.
  - `out` = NOP packet (`instruction=32'h00000013`, `pc=0`, `pc_plus4=0`, `valid_if_id=0`).
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble. Order is preserved across the wrap.

## Test plan
- **Reset and idle.** Assert `reset` 2 cycles with `in_valid=1`, then check the first post-reset cycle → `count=0`, `out_valid=0`, `out.instruction=32'h00000013`, `in_ready=1`.
- **Fill and stall.** DEPTH=4, `out_ready=0`, push pcs 0x00, 0x04, 0x08, 0x0C → `count=4`, `in_ready=0`. A fifth offer (pc 0x10) is not stored. `out.pc=0x00`.
- **Drain in order with wrap.** Continue from the full state: `out_ready=1` for 6 cycles while pushing 0x10 and 0x14 whenever `in_ready=1` → pops return 0x00, 0x04, 0x08, 0x0C, 0x10, 0x14 in order. `count` ends at 0.
- **Simultaneous push/pop at steady state.** count=2, `in_valid=out_ready=1` for 10 cycles → `count` stays 2. Output pcs increase by 4 each cycle.
- **Flush with concurrent push/pop.** count=3, assert `flush` together with `in_valid=1` (pc 0x40) and `out_ready=1` → next cycle `count=0`, `out_valid=0`, and 0x40 is never output. Then push branch target 0x80 → `out.pc=0x80` one cycle later.
- **Invalid input and mid-operation reset.** Offer a packet with `valid_if_id=0` → `count` unchanged. Then at count=3 assert `reset` together with push and pop → all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: first-word-fall-through FIFO of fetched packets,
// with back-pressure to fetch and a single-cycle discard on branch redirect.

package if_id_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
        logic        valid_if_id;
    } if_id_reg_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  if_id_reg_t                 in,
    output logic                       in_ready,
    input  logic                       flush,
    output if_id_reg_t                 out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if_id_reg_t         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               push;
    logic               pop;

    // Handshakes; packets fetched as bubbles are acknowledged but never stored
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != CNT_W'(0));
    assign push      = in_valid && in_ready && in.valid_if_id && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_q;

    always_comb begin
        out = '{pc: 32'h0, instruction: NOP_INSTR, pc_plus4: 32'h0, valid_if_id: 1'b0};
        if (out_valid) begin
            out             = mem_q[rd_ptr_q];
            out.valid_if_id = 1'b1;
        end
    end

    // Next-state pointers and occupancy; redirect empties the queue outright
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is live
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=4): fill/stall, ordered drain across the
// pointer wrap, steady-state streaming, redirect flush, bubbles and mid-run reset.

module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    if_id_reg_t  in_pkt;
    logic        in_ready;
    logic        flush;
    if_id_reg_t  out_pkt;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;

    int unsigned n_total  = 0;
    int unsigned n_passed = 0;
    logic        bound_en = 1'b0;

    logic [31:0] drain_exp [6];

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in_pkt),
        .in_ready  (in_ready),
        .flush     (flush),
        .out       (out_pkt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end else begin
            n_passed++;
        end
    endtask

    function automatic if_id_reg_t pkt(input logic [31:0] pc, input logic v);
        if_id_reg_t p;
        p.pc          = pc;
        p.instruction = 32'h0010_0093 + pc;
        p.pc_plus4    = pc + 32'd4;
        p.valid_if_id = v;
        return p;
    endfunction

    // Drive at the falling edge; the following rising edge consumes the inputs
    task automatic drive(input logic iv, input logic [31:0] pc, input logic v,
                         input logic ordy, input logic fl, input logic rst);
        @(negedge clk);
        in_valid  = iv;
        in_pkt    = pkt(pc, v);
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
    endtask

    task automatic idle_at_negedge();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        reset     = 1'b0;
    endtask

    // Occupancy must stay within 0..DEPTH on every cycle once reset has taken effect
    always @(negedge clk) begin
        if (bound_en) begin
            check("count_bound", 32'(count <= 3'(DEPTH)), 32'd1);
        end
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_pkt    = pkt(32'h100, 1'b1);
        drain_exp = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};

        // Reset and idle
        @(posedge clk);
        @(posedge clk);
        idle_at_negedge();
        bound_en = 1'b1;
        check("rst_count",     32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr",     out_pkt.instruction, 32'h13);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_pc",        out_pkt.pc, 32'd0);
        check("rst_vld",       32'(out_pkt.valid_if_id), 32'd0);

        // Fill and stall
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        idle_at_negedge();
        check("full_count",    32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head",     out_pkt.pc, 32'h00);
        check("full_valid",    32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_pkt   = pkt(32'h10, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("stall_count", 32'(count), 32'd4);
        check("stall_head",  out_pkt.pc, 32'h00);

        // Drain in order across the wrap; 0x10/0x14 enter while draining
        for (int i = 0; i < 6; i++) begin
            out_ready = 1'b1;
            in_valid  = (i == 1) || (i == 2);
            in_pkt    = pkt((i == 1) ? 32'h10 : 32'h14, 1'b1);
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_pc",    out_pkt.pc, drain_exp[i]);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("drain_count", 32'(count), 32'd0);
        check("drain_empty", 32'(out_valid), 32'd0);

        // Steady-state push/pop at count=2
        drive(1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h24, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h28 + 32'(4 * k), 1'b1, 1'b1, 1'b0, 1'b0);
            check("steady_count", 32'(count), 32'd2);
            check("steady_pc",    out_pkt.pc, 32'h20 + 32'(4 * k));
        end
        idle_at_negedge();
        check("steady_end_count", 32'(count), 32'd2);
        check("steady_end_head",  out_pkt.pc, 32'h48);

        // Flush with concurrent push and pop at count=3
        in_valid = 1'b1;
        in_pkt   = pkt(32'h50, 1'b1);
        @(negedge clk);
        check("pre_flush_count", 32'(count), 32'd3);
        in_pkt    = pkt(32'h40, 1'b1);
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        check("flush_count",    32'(count), 32'd0);
        check("flush_valid",    32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        in_pkt = pkt(32'h80, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("target_pc",    out_pkt.pc, 32'h80);
        check("target_valid", 32'(out_valid), 32'd1);
        check("target_count", 32'(count), 32'd1);
        check("target_pc4",   out_pkt.pc_plus4, 32'h84);

        // Bubble is acknowledged but not stored
        in_valid = 1'b1;
        in_pkt   = pkt(32'h84, 1'b0);
        @(negedge clk);
        check("bubble_count", 32'(count), 32'd1);
        check("bubble_head",  out_pkt.pc, 32'h80);
        check("bubble_ready", 32'(in_ready), 32'd1);

        // Mid-operation reset with push and pop at count=3
        in_pkt = pkt(32'h88, 1'b1);
        @(negedge clk);
        in_pkt = pkt(32'h8C, 1'b1);
        @(negedge clk);
        check("pre_rst_count", 32'(count), 32'd3);
        in_pkt    = pkt(32'h90, 1'b1);
        out_ready = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("mrst_count",    32'(count), 32'd0);
        check("mrst_valid",    32'(out_valid), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_instr",    out_pkt.instruction, 32'h13);
        check("mrst_pc",       out_pkt.pc, 32'd0);
        check("mrst_pc4",      out_pkt.pc_plus4, 32'd0);
        check("mrst_vld",      32'(out_pkt.valid_if_id), 32'd0);

        // First packet after reset flows through normally
        drive(1'b1, 32'hA0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_at_negedge();
        check("post_rst_pc",    out_pkt.pc, 32'hA0);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_instr", out_pkt.instruction, 32'h0010_0093 + 32'hA0);

        bound_en = 1'b0;
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
